// File: rtl/sprite_reader.sv
// Sprite/tile window reader: walks a width x height window out of a 1-cycle-latency RAM
// and streams it as valid/ready pixels. Optional colour-key flag via SPRITE_COLORKEY_EN.
module sprite_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DIM_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DIM_WIDTH-1:0]  win_w,
    input  logic [DIM_WIDTH-1:0]  win_h,
    input  logic [ADDR_WIDTH-1:0] stride,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_last
`ifdef SPRITE_COLORKEY_EN
    ,
    input  logic [DATA_WIDTH-1:0] key_color,
    output logic                  pix_opaque
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [DIM_WIDTH-1:0] DIM_ONE = 1;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] row_addr;
    logic [ADDR_WIDTH-1:0] stride_r;
    logic [DIM_WIDTH-1:0]  w_last;
    logic [DIM_WIDTH-1:0]  h_last;
    logic [DIM_WIDTH-1:0]  col;
    logic [DIM_WIDTH-1:0]  row;
    logic                  in_flight;
    logic                  in_flight_last;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_last;
    logic [1:0]            count;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic                  done_r;

    logic                  accept;
    logic                  zero_win;
    logic                  col_end;
    logic                  issue_last;
    logic                  issue;
    logic                  fifo_has;
    logic                  pop;
    logic                  fifo_pop;
    logic                  push;
    logic [2:0]            occupancy;

    // The head is the FIFO when it holds data, otherwise the RAM response
    // falls straight through so the first pixel shows up with no extra cycle.
    always_comb begin
        accept     = start && (state == IDLE);
        zero_win   = (win_w == '0) || (win_h == '0);
        col_end    = (col == w_last);
        issue_last = col_end && (row == h_last);
        fifo_has   = (count != 2'd0);
        pix_valid  = fifo_has || in_flight;
        pop        = pix_valid && pix_ready;
        fifo_pop   = pop && fifo_has;
        push       = in_flight && (fifo_has || !pix_ready);
        occupancy  = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
        issue      = (state == FETCH) && (occupancy < 3'd2);
        pix_data   = '0;
        pix_last   = 1'b0;
        if (fifo_has) begin
            pix_data = fifo_data[rd_ptr];
            pix_last = fifo_last[rd_ptr];
        end else if (in_flight) begin
            pix_data = mem_rdata;
            pix_last = in_flight_last;
        end
    end

    assign mem_en   = issue;
    assign mem_we   = 1'b0;
    assign mem_addr = issue ? (row_addr + ADDR_WIDTH'(col)) : '0;
    assign busy     = (state != IDLE);
    assign done     = done_r;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !zero_win) state_next = FETCH;
            FETCH:   if (issue && issue_last) state_next = DRAIN;
            DRAIN:   if (pop && pix_last)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Window geometry is stored as last-index values so the walk compares directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_addr <= '0;
            stride_r <= '0;
            w_last   <= '0;
            h_last   <= '0;
            col      <= '0;
            row      <= '0;
        end else if (accept && !zero_win) begin
            row_addr <= base_addr;
            stride_r <= stride;
            w_last   <= win_w - DIM_ONE;
            h_last   <= win_h - DIM_ONE;
            col      <= '0;
            row      <= '0;
        end else if (issue) begin
            if (col_end) begin
                col      <= '0;
                row      <= row + DIM_ONE;
                row_addr <= row_addr + stride_r;
            end else begin
                col <= col + DIM_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            in_flight      <= issue;
            in_flight_last <= issue && issue_last;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            count        <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_rdata;
                fifo_last[wr_ptr] <= in_flight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (fifo_pop) rd_ptr <= ~rd_ptr;
            case ({push, fifo_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) done_r <= 1'b0;
        else          done_r <= (accept && zero_win) || ((state == DRAIN) && pop && pix_last);
    end

`ifdef SPRITE_COLORKEY_EN
    logic [DATA_WIDTH-1:0] key_r;
    logic [1:0]            fifo_opaque;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_r       <= '0;
            fifo_opaque <= '0;
        end else begin
            if (accept) key_r <= key_color;
            if (push) fifo_opaque[wr_ptr] <= (mem_rdata != key_r);
        end
    end

    always_comb begin
        pix_opaque = 1'b0;
        if (fifo_has)       pix_opaque = fifo_opaque[rd_ptr];
        else if (in_flight) pix_opaque = (mem_rdata != key_r);
    end
`endif

endmodule

// File: tb/tb_sprite_reader.sv
// Self-checking bench for sprite_reader: table of windows plus hand-written stall,
// zero-size, mid-window reset and (with SPRITE_COLORKEY_EN) colour-key sequences.
module tb_sprite_reader;

    typedef struct {
        logic [15:0] base;
        logic [7:0]  w;
        logic [7:0]  h;
        logic [15:0] stride;
        int          mode;
        bit          restart;
        int          n;
        logic [63:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] base_addr;
    logic [7:0]  win_w;
    logic [7:0]  win_h;
    logic [15:0] stride;
    logic        busy;
    logic        done;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
`ifdef SPRITE_COLORKEY_EN
    logic [7:0]  key_color;
    logic        pix_opaque;
`endif

    int tests = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;
    int start_cyc = 0;

    int issued, popped, first_valid_cyc, first_pop_cyc, last_pop_cyc;
    int done_cnt, done_cyc, stall_err, flight_err, we_err;
    bit busy_seen, prev_stall, prev_last;
    logic [7:0]  prev_data;
    logic [15:0] addr_q[$];
    logic [7:0]  pix_q[$];
    bit          last_q[$];
    bit          opq_q[$];

    vec_t vecs[5];

    always #5 clk = ~clk;

    // RAM model: every address holds its own low byte.
    always @(posedge clk) if (mem_en) mem_rdata <= mem_addr[7:0];

    sprite_reader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .win_w     (win_w),
        .win_h     (win_h),
        .stride    (stride),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last)
`ifdef SPRITE_COLORKEY_EN
        ,
        .key_color (key_color),
        .pix_opaque(pix_opaque)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        issued = 0; popped = 0; first_valid_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
        done_cnt = 0; done_cyc = -1; stall_err = 0; flight_err = 0; we_err = 0;
        busy_seen = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
        addr_q.delete(); pix_q.delete(); last_q.delete(); opq_q.delete();
    endtask

    task automatic sample();
        if (mem_en) begin
            addr_q.push_back(mem_addr);
            issued++;
        end
        if (mem_we) we_err++;
        if (busy) busy_seen = 1;
        if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_stall && !(pix_valid && pix_data == prev_data && pix_last == prev_last)) stall_err++;
        if (pix_valid && pix_ready) begin
            pix_q.push_back(pix_data);
            last_q.push_back(pix_last);
`ifdef SPRITE_COLORKEY_EN
            opq_q.push_back(pix_opaque);
`endif
            popped++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        if (issued - popped > 2) flight_err++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_stall = pix_valid && !pix_ready;
        prev_data  = pix_data;
        prev_last  = pix_last;
    endtask

    // One clock: inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
    task automatic applyStimulus(input logic st);
        @(posedge clk);
        #1;
        cyc++;
        start = st;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ~pix_ready;
            default: pix_ready = 1'b0;
        endcase
        @(negedge clk);
        sample();
    endtask

    task automatic run_window(input vec_t v, input int idx);
        logic [15:0] a;
        clear_mon();
        base_addr = v.base; win_w = v.w; win_h = v.h; stride = v.stride; ready_mode = v.mode;
        applyStimulus(1'b1);
        start_cyc = cyc;
        for (int k = 1; k < 200 && done_cnt == 0; k++) begin
            if (v.restart && k == 3) begin
                base_addr = 16'h0AAA;
                win_w = 8'd1;
                applyStimulus(1'b1);
            end else begin
                applyStimulus(1'b0);
            end
        end
        repeat (2) applyStimulus(1'b0);
        checkOutput($sformatf("v%0d_done_count", idx), done_cnt, 1);
        checkOutput($sformatf("v%0d_pix_count", idx), pix_q.size(), v.n);
        checkOutput($sformatf("v%0d_addr_count", idx), addr_q.size(), v.n);
        for (int i = 0; i < v.n; i++) begin
            if (i < pix_q.size()) begin
                checkOutput($sformatf("v%0d_pix%0d", idx, i), pix_q[i], v.exp[8*i +: 8]);
                checkOutput($sformatf("v%0d_last%0d", idx, i), last_q[i], (i == v.n - 1));
            end
            if (i < addr_q.size()) begin
                a = v.base + v.stride * 16'(i / int'(v.w)) + 16'(i % int'(v.w));
                checkOutput($sformatf("v%0d_addr%0d", idx, i), addr_q[i], a);
            end
        end
        checkOutput($sformatf("v%0d_first_latency", idx), first_valid_cyc - start_cyc, 2);
        checkOutput($sformatf("v%0d_done_delay", idx), done_cyc - last_pop_cyc, 1);
        checkOutput($sformatf("v%0d_stall_stable", idx), stall_err, 0);
        checkOutput($sformatf("v%0d_inflight", idx), flight_err, 0);
        checkOutput($sformatf("v%0d_mem_we", idx), we_err, 0);
        checkOutput($sformatf("v%0d_busy_end", idx), busy, 0);
        if (v.mode == 0)
            checkOutput($sformatf("v%0d_throughput", idx), last_pop_cyc - first_pop_cyc, v.n - 1);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t v;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; win_w = '0; win_h = '0; stride = '0;
        pix_ready = 1'b1;
`ifdef SPRITE_COLORKEY_EN
        key_color = 8'h00;
`endif
        vecs[0] = '{16'h0100, 8'd4, 8'd2, 16'h0010, 0, 1'b0, 8, 64'h1312_1110_0302_0100};
        vecs[1] = '{16'h0100, 8'd4, 8'd2, 16'h0010, 1, 1'b0, 8, 64'h1312_1110_0302_0100};
        vecs[2] = '{16'hFFFE, 8'd4, 8'd1, 16'h0010, 0, 1'b0, 4, 64'h0000_0000_0100_FFFE};
        vecs[3] = '{16'h0030, 8'd2, 8'd3, 16'hFFF0, 1, 1'b1, 6, 64'h0000_1110_2120_3130};
        vecs[4] = '{16'h0055, 8'd1, 8'd1, 16'h0000, 0, 1'b0, 1, 64'h0000_0000_0000_0055};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", {busy, done, mem_en, pix_valid, pix_last, mem_we}, 6'b0);
        checkOutput("reset_addr", mem_addr, 16'h0000);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_window(vecs[i], i);

        // Consumer stalled: only two reads may be outstanding, head must hold still.
        clear_mon();
        base_addr = 16'h0300; win_w = 8'd4; win_h = 8'd1; stride = 16'h0000; ready_mode = 2;
        applyStimulus(1'b1);
        repeat (10) applyStimulus(1'b0);
        checkOutput("stall_issued", issued, 2);
        checkOutput("stall_popped", popped, 0);
        checkOutput("stall_valid", pix_valid, 1);
        checkOutput("stall_data", pix_data, 8'h00);
        ready_mode = 0;
        for (int k = 0; k < 30 && done_cnt == 0; k++) applyStimulus(1'b0);
        checkOutput("stall_count", pix_q.size(), 4);
        for (int i = 0; i < 4 && i < pix_q.size(); i++)
            checkOutput($sformatf("stall_pix%0d", i), pix_q[i], i);
        checkOutput("stall_stable", stall_err, 0);
        checkOutput("stall_done", done_cnt, 1);

        // Zero-width window completes immediately without touching the RAM.
        clear_mon();
        base_addr = 16'h0400; win_w = 8'd0; win_h = 8'd5; ready_mode = 0;
        applyStimulus(1'b1);
        start_cyc = cyc;
        repeat (4) applyStimulus(1'b0);
        checkOutput("zero_mem_en", issued, 0);
        checkOutput("zero_valid", first_valid_cyc, -1);
        checkOutput("zero_done_count", done_cnt, 1);
        checkOutput("zero_done_delay", done_cyc - start_cyc, 1);
        checkOutput("zero_busy", busy_seen, 0);

        // Reset in the middle of a 4x4 window.
        clear_mon();
        base_addr = 16'h0200; win_w = 8'd4; win_h = 8'd4; stride = 16'h0010; ready_mode = 0;
        applyStimulus(1'b1);
        for (int k = 0; k < 20 && popped < 3; k++) applyStimulus(1'b0);
        checkOutput("rst_pre_busy", busy, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_async_ctrl", {busy, done, mem_en, pix_valid, pix_last}, 5'b0);
        checkOutput("rst_async_addr", mem_addr, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_mon();
        repeat (3) applyStimulus(1'b0);
        checkOutput("rst_idle_pix", popped, 0);
        checkOutput("rst_idle_mem", issued, 0);
        v = '{16'h0020, 8'd1, 8'd1, 16'h0000, 0, 1'b0, 1, 64'h20};
        run_window(v, 10);

`ifdef SPRITE_COLORKEY_EN
        begin
            logic [2:0] exp_op;
            exp_op = 3'b101;
            key_color = 8'h11;
            v = '{16'h0010, 8'd3, 8'd1, 16'h0000, 0, 1'b0, 3, 64'h12_1110};
            run_window(v, 20);
            checkOutput("key_count", opq_q.size(), 3);
            for (int i = 0; i < 3 && i < opq_q.size(); i++)
                checkOutput($sformatf("key_opaque%0d", i), opq_q[i], exp_op[i]);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
